// File: rtl/cpu_pkg.sv
// Shared constants and loader state encoding for the CPU bootloader slice.
package cpu_pkg;

  localparam int DATA_WIDTH           = 4;
  localparam int MEMORY_ADDRESS_WIDTH = 4;
  localparam int MEMORY_REGISTERS     = 16;
  localparam int SYNC_STAGES          = 2;

  typedef enum logic [2:0] {
    BL_IDLE,
    BL_LOAD,
    BL_CHECK,
    BL_DONE,
    BL_ERROR
  } blState_e;

endpackage

// File: rtl/bl_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with a registered
// rising-edge pulse on the synchronized level.
module bl_sync_edge #(
  parameter int STAGES = cpu_pkg::SYNC_STAGES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic async_i,
  output logic sync_o,
  output logic rise_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q[0] <= async_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign sync_o = sync_q[STAGES-1];
  assign rise_o = rise_q;

endmodule

// File: rtl/cpu_bootloader.sv
// Nibble-serial program loader: fills instruction memory from board pins,
// then verifies an XOR checksum before releasing the CPU.
module cpu_bootloader #(
  parameter int DATA_WIDTH           = cpu_pkg::DATA_WIDTH,
  parameter int MEMORY_ADDRESS_WIDTH = cpu_pkg::MEMORY_ADDRESS_WIDTH,
  parameter int MEMORY_REGISTERS     = cpu_pkg::MEMORY_REGISTERS,
  parameter int SYNC_STAGES          = cpu_pkg::SYNC_STAGES
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            prog_en_i,
  input  logic                            strobe_i,
  input  logic [DATA_WIDTH-1:0]           data_i,
  output logic                            bl_programm_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
  output logic [DATA_WIDTH-1:0]           bl_data_o,
  output logic                            bl_write_en_mem_o,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            error_o
);

  import cpu_pkg::*;

  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LastAddr =
    MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);
  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] AddrOne = MEMORY_ADDRESS_WIDTH'(1);

  logic progLevel, progRise, strobeLevelUnused, strobeRise;
  logic [DATA_WIDTH-1:0] dataSync_q [SYNC_STAGES];
  logic [DATA_WIDTH-1:0] dataNow;

  blState_e state_q, state_d;
  logic [MEMORY_ADDRESS_WIDTH-1:0] addr_q, addr_d, blAddr_q, blAddr_d;
  logic [DATA_WIDTH-1:0]           acc_q, acc_d, blData_q, blData_d;
  logic                            we_q, we_d;
  logic                            writeFire;

  bl_sync_edge #(.STAGES(SYNC_STAGES)) uProgSync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (prog_en_i),
    .sync_o  (progLevel),
    .rise_o  (progRise)
  );

  bl_sync_edge #(.STAGES(SYNC_STAGES)) uStrobeSync (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .async_i (strobe_i),
    .sync_o  (strobeLevelUnused),
    .rise_o  (strobeRise)
  );

  // Data gets the same depth as strobe so both arrive aligned.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        dataSync_q[i] <= '0;
      end
    end else begin
      dataSync_q[0] <= data_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        dataSync_q[i] <= dataSync_q[i-1];
      end
    end
  end

  assign dataNow   = dataSync_q[SYNC_STAGES-1];
  assign writeFire = (state_q == BL_LOAD) && strobeRise && progLevel;

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q <= BL_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BL_IDLE: begin
        if (progRise) state_d = BL_LOAD;
      end
      BL_LOAD: begin
        if (!progLevel) state_d = BL_IDLE;
        else if (strobeRise && addr_q == LastAddr) state_d = BL_CHECK;
      end
      BL_CHECK: begin
        if (!progLevel) state_d = BL_IDLE;
        else if (strobeRise) state_d = (dataNow == acc_q) ? BL_DONE : BL_ERROR;
      end
      BL_DONE, BL_ERROR: begin
        if (!progLevel) state_d = BL_IDLE;
      end
      default: state_d = BL_IDLE;
    endcase
  end

  always_comb begin
    bl_programm_o = 1'b0;
    busy_o        = 1'b0;
    done_o        = 1'b0;
    error_o       = 1'b0;
    case (state_q)
      BL_LOAD, BL_CHECK: begin
        bl_programm_o = 1'b1;
        busy_o        = 1'b1;
      end
      BL_DONE:  done_o  = 1'b1;
      BL_ERROR: error_o = 1'b1;
      default: ;
    endcase
  end

  // Address counter wraps after the last word so no write lands past memory.
  always_comb begin
    addr_d   = addr_q;
    acc_d    = acc_q;
    blAddr_d = blAddr_q;
    blData_d = blData_q;
    we_d     = 1'b0;
    if (state_q == BL_IDLE && progRise) begin
      addr_d = '0;
      acc_d  = '0;
    end
    if (writeFire) begin
      blAddr_d = addr_q;
      blData_d = dataNow;
      we_d     = 1'b1;
      acc_d    = acc_q ^ dataNow;
      addr_d   = (addr_q == LastAddr) ? '0 : addr_q + AddrOne;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      addr_q   <= '0;
      acc_q    <= '0;
      blAddr_q <= '0;
      blData_q <= '0;
      we_q     <= 1'b0;
    end else begin
      addr_q   <= addr_d;
      acc_q    <= acc_d;
      blAddr_q <= blAddr_d;
      blData_q <= blData_d;
      we_q     <= we_d;
    end
  end

  assign bl_address_o      = blAddr_q;
  assign bl_data_o         = blData_q;
  assign bl_write_en_mem_o = we_q;

endmodule

// File: tb/tb_cpu_bootloader.sv
// Directed bench for cpu_bootloader: full loads, checksum error, abort,
// mid-session reset, strobe handling and write latency.
module tb_cpu_bootloader;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       prog_en_i;
  logic       strobe_i;
  logic [3:0] data_i;
  logic       bl_programm_o;
  logic [3:0] bl_address_o;
  logic [3:0] bl_data_o;
  logic       bl_write_en_mem_o;
  logic       busy_o;
  logic       done_o;
  logic       error_o;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int kCycle;

  logic [3:0] wrAddrQ [$];
  logic [3:0] wrDataQ [$];
  int         wrCycleQ [$];

  logic [3:0] progTable [16] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8,
                                 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0};

  cpu_bootloader dut (
    .clk_i             (clk_i),
    .reset_i           (reset_i),
    .prog_en_i         (prog_en_i),
    .strobe_i          (strobe_i),
    .data_i            (data_i),
    .bl_programm_o     (bl_programm_o),
    .bl_address_o      (bl_address_o),
    .bl_data_o         (bl_data_o),
    .bl_write_en_mem_o (bl_write_en_mem_o),
    .busy_o            (busy_o),
    .done_o            (done_o),
    .error_o           (error_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle <= cycle + 1;

  // Every write pulse observed mid-cycle is logged with its cycle number.
  always @(negedge clk_i) begin
    if (bl_write_en_mem_o) begin
      wrAddrQ.push_back(bl_address_o);
      wrDataQ.push_back(bl_data_o);
      wrCycleQ.push_back(cycle);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic clearLog();
    wrAddrQ.delete();
    wrDataQ.delete();
    wrCycleQ.delete();
  endtask

  task automatic applyStimulus(input logic [3:0] nib);
    data_i = nib;
    @(negedge clk_i);
    strobe_i = 1'b1;
    repeat (3) @(negedge clk_i);
    strobe_i = 1'b0;
    repeat (4) @(negedge clk_i);
  endtask

  task automatic startSession();
    prog_en_i = 1'b1;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic endSession();
    prog_en_i = 1'b0;
    repeat (5) @(negedge clk_i);
  endtask

  task automatic checkFullLoad(input string tag);
    checkOutput({tag, "_wcount"}, wrAddrQ.size(), 16);
    if (wrAddrQ.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        checkOutput($sformatf("%s_addr%0d", tag, i), wrAddrQ[i], i);
        checkOutput($sformatf("%s_data%0d", tag, i), wrDataQ[i], progTable[i]);
      end
    end
  endtask

  initial begin
    reset_i   = 1'b0;
    prog_en_i = 1'b0;
    strobe_i  = 1'b0;
    data_i    = 4'h0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_outs", {bl_programm_o, bl_write_en_mem_o, busy_o, done_o, error_o}, 5'b0);
    checkOutput("rst_addr", bl_address_o, 0);
    checkOutput("rst_data", bl_data_o, 0);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("[TB] good load");
    clearLog();
    startSession();
    checkOutput("s1_busy", busy_o, 1);
    checkOutput("s1_prog", bl_programm_o, 1);
    for (int i = 0; i < 16; i++) applyStimulus(progTable[i]);
    checkOutput("s1_check_busy", busy_o, 1);
    applyStimulus(4'h0);
    checkFullLoad("s1");
    checkOutput("s1_done", done_o, 1);
    checkOutput("s1_err", error_o, 0);
    checkOutput("s1_prog_after", bl_programm_o, 0);
    checkOutput("s1_busy_after", busy_o, 0);
    endSession();
    checkOutput("s1_done_clr", done_o, 0);

    $display("[TB] bad checksum");
    clearLog();
    startSession();
    for (int i = 0; i < 16; i++) applyStimulus(progTable[i]);
    applyStimulus(4'h5);
    checkFullLoad("s2");
    checkOutput("s2_err", error_o, 1);
    checkOutput("s2_done", done_o, 0);
    checkOutput("s2_prog", bl_programm_o, 0);
    endSession();
    checkOutput("s2_err_clr", error_o, 0);

    $display("[TB] abort after 7");
    clearLog();
    startSession();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(progTable[i]);
      checkOutput($sformatf("ab_count%0d", i), wrAddrQ.size(), i + 1);
    end
    endSession();
    checkOutput("ab_wcount", wrAddrQ.size(), 7);
    checkOutput("ab_flags", {bl_programm_o, busy_o, done_o, error_o}, 4'b0);
    checkOutput("ab_addr_hold", bl_address_o, 6);
    checkOutput("ab_data_hold", bl_data_o, 4'h7);
    applyStimulus(4'h9);
    applyStimulus(4'hC);
    checkOutput("idle_strobe", wrAddrQ.size(), 7);

    $display("[TB] reset mid-load");
    clearLog();
    startSession();
    for (int i = 0; i < 9; i++) applyStimulus(progTable[i]);
    checkOutput("mr_addr_pre", bl_address_o, 8);
    checkOutput("mr_busy_pre", busy_o, 1);
    #1 reset_i = 1'b0;
    #1;
    checkOutput("mr_outs", {bl_programm_o, bl_write_en_mem_o, busy_o, done_o, error_o}, 5'b0);
    checkOutput("mr_addr", bl_address_o, 0);
    checkOutput("mr_data", bl_data_o, 0);
    prog_en_i = 1'b0;
    repeat (3) @(negedge clk_i);
    reset_i = 1'b1;
    repeat (2) @(negedge clk_i);

    $display("[TB] new session and latency");
    clearLog();
    startSession();
    data_i = 4'hA;
    @(negedge clk_i);
    strobe_i = 1'b1;
    @(negedge clk_i);
    kCycle = cycle;
    repeat (2) @(negedge clk_i);
    strobe_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkOutput("lat_wcount", wrAddrQ.size(), 1);
    if (wrAddrQ.size() == 1) begin
      checkOutput("lat_cycle", wrCycleQ[0], kCycle + 3);
      checkOutput("lat_addr", wrAddrQ[0], 0);
      checkOutput("lat_data", wrDataQ[0], 4'hA);
    end
    applyStimulus(4'h3);
    checkOutput("lat_wcount2", wrAddrQ.size(), 2);
    if (wrAddrQ.size() == 2) begin
      checkOutput("lat_addr2", wrAddrQ[1], 1);
      checkOutput("lat_data2", wrDataQ[1], 4'h3);
    end
    endSession();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
